// File: rtl/word_stacker_pkg.sv
// Shared AES stream package.
// Provides the default word/block geometry used between the 32-bit streamer
// side and the 128-bit AES datapath, plus typedefs for both widths.
package word_stacker_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 4;
  localparam int BLOCK_W = WORD_W * N_WORDS;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

endpackage : word_stacker_pkg

// File: rtl/word_stacker.sv
// word_stacker
// Packs N_WORDS consecutive accepted input words into one BLOCK_W output
// block. The first word of a block lands in the most significant lane.
// A one-block output register lets collection of the next block continue
// while the previous block waits for the consumer.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   clr_i     synchronous soft clear (discards partial and pending blocks)
//   enable_i  global enable; when low all state holds and no transfer occurs
//   valid_i   input word valid
//   ready_o   input ready
//   word_i    input word
//   valid_o   output block valid
//   ready_i   downstream ready
//   word_o    output block (driven regardless of valid_o)
module word_stacker #(
  parameter int WORD_W  = word_stacker_pkg::WORD_W,
  parameter int N_WORDS = word_stacker_pkg::N_WORDS,
  parameter int BLOCK_W = WORD_W * N_WORDS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               enable_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WORD_W-1:0]  word_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BLOCK_W-1:0] word_o
);

  import word_stacker_pkg::*;

  localparam int ACC_W  = WORD_W * (N_WORDS - 1);
  localparam int CNT_W  = $clog2(N_WORDS);
  localparam int LSB_W  = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [BLOCK_W-1:0] out_r;
  logic               out_vld_r;

  logic               full_s;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               last_word_s;
  logic [LSB_W-1:0]   lane_lsb_s;

  // Handshake decode. ready_o depends only on registered state and enable_i,
  // so there is no combinational path from ready_i to ready_o.
  always_comb begin
    last_word_s = (cnt_r == LAST_IDX);
    full_s      = last_word_s & out_vld_r;
    ready_o     = enable_i & ~full_s;
    valid_o     = enable_i & out_vld_r;
    word_o      = out_r;
    in_fire_s   = enable_i & valid_i & ready_o;
    out_fire_s  = enable_i & valid_o & ready_i;
    // Lane k of the accumulator sits at [ACC_W-1-k*WORD_W -: WORD_W].
    // For the last index this value is meaningless; it is only used when
    // cnt_r is below the last index.
    lane_lsb_s  = LSB_W'(ACC_W - WORD_W * (int'(cnt_r) + 1));
  end

  // Counter, accumulator and output slot. Clear wins over an input word
  // presented in the same cycle; a completing word and a pop in the same
  // cycle keep the slot valid with the new block.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_r     <= '0;
      acc_r     <= '0;
      out_r     <= '0;
      out_vld_r <= 1'b0;
    end else if (enable_i) begin
      if (in_fire_s && last_word_s) begin
        out_r     <= {acc_r, word_i};
        out_vld_r <= 1'b1;
        cnt_r     <= '0;
      end else begin
        if (in_fire_s) begin
          acc_r[lane_lsb_s +: WORD_W] <= word_i;
          cnt_r                       <= cnt_r + CNT_W'(1);
        end
        if (out_fire_s) begin
          out_vld_r <= 1'b0;
        end
      end
    end
  end

endmodule : word_stacker
